multiciclo_control: RTL and testbench

MULTICICLO_CONTROL -- requirements
Module: multiciclo_control

---
 rtl/mips_pkg.sv | 45 ++++
 rtl/multiciclo_control.sv | 177 +++++++++++++++++
 tb/tb_multiciclo_control.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// Shared definitions for the multicycle MIPS control path: state encoding,
// opcode constants and the ALUOp / PCSource encodings.
package mips_pkg;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_ADDIEX = 4'd9,
    S_ADDIWB = 4'd10,
    S_JUMP   = 4'd11
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  // States that wait on mem_ready and are therefore covered by the timeout.
  function automatic logic is_mem_state(input state_e s);
    logic r;
    case (s)
      S_FETCH, S_MEMRD, S_MEMWR: r = 1'b1;
      default:                   r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/multiciclo_control.sv
// Multicycle MIPS control FSM with a bounded wait on memory handshakes.
// Control outputs decode from the current state; a timeout aborts to FETCH.
module multiciclo_control
  import mips_pkg::*;
#(
  parameter int unsigned MAX_WAIT = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] op_code,
  input  logic       Zero,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       MemtoReg,
  output logic       RegDst,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic [1:0] PCSource,
  output logic       illegal_op,
  output logic       mem_err,
  output logic [3:0] state_o
);

  localparam int unsigned CW = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;

  state_e        state_q, state_d;
  logic [CW-1:0] wait_q;
  logic          timeout_s;
  logic          zero_unused;

  // The branch decision (PCWriteCond & Zero) is taken in the datapath.
  assign zero_unused = Zero;

  // The last permitted waiting cycle expires unless memory answers in it.
  assign timeout_s = is_mem_state(state_q) && !mem_ready &&
                     (wait_q == CW'(MAX_WAIT - 1));

  assign state_o = state_q;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  // Wait counter: restarts on any state change or timeout.
  always_ff @(posedge clk) begin
    if (rst) begin
      wait_q <= '0;
    end else if ((state_d != state_q) || timeout_s) begin
      wait_q <= '0;
    end else if (is_mem_state(state_q) && !mem_ready) begin
      wait_q <= wait_q + CW'(1);
    end else begin
      wait_q <= wait_q;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH: begin
        if (timeout_s)      state_d = S_FETCH;
        else if (mem_ready) state_d = S_DECODE;
        else                state_d = S_FETCH;
      end
      S_DECODE: begin
        case (op_code)
          OP_RTYPE:     state_d = S_EXEC;
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_BEQ:       state_d = S_BRANCH;
          OP_J:         state_d = S_JUMP;
          OP_ADDI:      state_d = S_ADDIEX;
          default:      state_d = S_FETCH;
        endcase
      end
      S_MEMADR: begin
        if (op_code == OP_SW) state_d = S_MEMWR;
        else                  state_d = S_MEMRD;
      end
      S_MEMRD: begin
        if (timeout_s)      state_d = S_FETCH;
        else if (mem_ready) state_d = S_MEMWB;
        else                state_d = S_MEMRD;
      end
      S_MEMWR: begin
        if (timeout_s || mem_ready) state_d = S_FETCH;
        else                        state_d = S_MEMWR;
      end
      S_EXEC:   state_d = S_ALUWB;
      S_ADDIEX: state_d = S_ADDIWB;
      default:  state_d = S_FETCH;
    endcase
  end

  // Output decode.
  always_comb begin
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    IRWrite     = 1'b0;
    MemtoReg    = 1'b0;
    RegDst      = 1'b0;
    RegWrite    = 1'b0;
    ALUSrcA     = 1'b0;
    ALUSrcB     = 2'b00;
    ALUOp       = ALUOP_ADD;
    PCSource    = PCSRC_ALU;
    illegal_op  = 1'b0;
    mem_err     = timeout_s;
    case (state_q)
      S_FETCH: begin
        MemRead = 1'b1;
        ALUSrcB = 2'b01;
        IRWrite = mem_ready;
        PCWrite = mem_ready;
      end
      S_DECODE: begin
        ALUSrcB = 2'b11;
        case (op_code)
          OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI: illegal_op = 1'b0;
          default:                                       illegal_op = 1'b1;
        endcase
      end
      S_MEMADR, S_ADDIEX: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
      end
      S_MEMRD: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
      end
      S_MEMWR: begin
        MemWrite = !timeout_s;
        IorD     = 1'b1;
      end
      S_MEMWB: begin
        RegWrite = 1'b1;
        MemtoReg = 1'b1;
      end
      S_EXEC: begin
        ALUSrcA = 1'b1;
        ALUOp   = ALUOP_FUNCT;
      end
      S_ALUWB: begin
        RegWrite = 1'b1;
        RegDst   = 1'b1;
      end
      S_ADDIWB: RegWrite = 1'b1;
      S_BRANCH: begin
        ALUSrcA     = 1'b1;
        ALUOp       = ALUOP_SUB;
        PCWriteCond = 1'b1;
        PCSource    = PCSRC_ALUOUT;
      end
      S_JUMP: begin
        PCWrite  = 1'b1;
        PCSource = PCSRC_JUMP;
      end
      default: PCWrite = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_multiciclo_control.sv
// Directed bench for multiciclo_control: expected state and control vector are
// queued per cycle and compared at the falling edge.
module tb_multiciclo_control;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] op_code;
  logic       Zero;
  logic       mem_ready;

  logic       pcw_a, pcwc_a, iord_a, mrd_a, mwr_a, irw_a, m2r_a, rdst_a, rw_a, asa_a;
  logic [1:0] asb_a, aop_a, pcs_a;
  logic       ill_a, err_a;
  logic [3:0] st_a;
  logic       pcw_b, pcwc_b, iord_b, mrd_b, mwr_b, irw_b, m2r_b, rdst_b, rw_b, asa_b;
  logic [1:0] asb_b, aop_b, pcs_b;
  logic       ill_b, err_b;
  logic [3:0] st_b;

  typedef struct packed {
    logic [3:0]  st;
    logic [17:0] ctrl;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  logic        use4 = 1'b0;
  logic [3:0]  obs_st;
  logic [17:0] obs_ctrl;

  always #5 clk = ~clk;

  multiciclo_control dut (
    .clk(clk), .rst(rst), .op_code(op_code), .Zero(Zero), .mem_ready(mem_ready),
    .PCWrite(pcw_a), .PCWriteCond(pcwc_a), .IorD(iord_a), .MemRead(mrd_a),
    .MemWrite(mwr_a), .IRWrite(irw_a), .MemtoReg(m2r_a), .RegDst(rdst_a),
    .RegWrite(rw_a), .ALUSrcA(asa_a), .ALUSrcB(asb_a), .ALUOp(aop_a),
    .PCSource(pcs_a), .illegal_op(ill_a), .mem_err(err_a), .state_o(st_a)
  );

  multiciclo_control #(.MAX_WAIT(4)) dut4 (
    .clk(clk), .rst(rst), .op_code(op_code), .Zero(Zero), .mem_ready(mem_ready),
    .PCWrite(pcw_b), .PCWriteCond(pcwc_b), .IorD(iord_b), .MemRead(mrd_b),
    .MemWrite(mwr_b), .IRWrite(irw_b), .MemtoReg(m2r_b), .RegDst(rdst_b),
    .RegWrite(rw_b), .ALUSrcA(asa_b), .ALUSrcB(asb_b), .ALUOp(aop_b),
    .PCSource(pcs_b), .illegal_op(ill_b), .mem_err(err_b), .state_o(st_b)
  );

  always_comb begin
    if (use4) begin
      obs_st   = st_b;
      obs_ctrl = {pcw_b, pcwc_b, iord_b, mrd_b, mwr_b, irw_b, m2r_b, rdst_b, rw_b,
                  asa_b, asb_b, aop_b, pcs_b, ill_b, err_b};
    end else begin
      obs_st   = st_a;
      obs_ctrl = {pcw_a, pcwc_a, iord_a, mrd_a, mwr_a, irw_a, m2r_a, rdst_a, rw_a,
                  asa_a, asb_a, aop_a, pcs_a, ill_a, err_a};
    end
  end

  // Reference control table, one row per state.
  function automatic logic [17:0] exp_ctrl(input logic [3:0] st, input logic mr,
                                           input logic ill, input logic err);
    logic pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rw, asa;
    logic [1:0] asb, aop, pcs;
    {pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rw, asa} = 10'b0;
    asb = 2'b00; aop = 2'b00; pcs = 2'b00;
    case (st)
      4'd0:  begin mrd = 1'b1; asb = 2'b01; irw = mr; pcw = mr; end
      4'd1:  asb = 2'b11;
      4'd2, 4'd9: begin asa = 1'b1; asb = 2'b10; end
      4'd3:  begin mrd = 1'b1; iord = 1'b1; end
      4'd4:  begin rw = 1'b1; m2r = 1'b1; end
      4'd5:  begin mwr = !err; iord = 1'b1; end
      4'd6:  begin asa = 1'b1; aop = 2'b10; end
      4'd7:  begin rw = 1'b1; rdst = 1'b1; end
      4'd8:  begin asa = 1'b1; aop = 2'b01; pcwc = 1'b1; pcs = 2'b01; end
      4'd10: rw = 1'b1;
      4'd11: begin pcw = 1'b1; pcs = 2'b10; end
      default: pcw = 1'b0;
    endcase
    return {pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rw, asa, asb, aop, pcs, ill, err};
  endfunction

  // One clock cycle: queue the expectation, compare at negedge, advance.
  task automatic cycle(input logic [3:0] st, input logic ill, input logic err,
                       input string tag);
    exp_t e;
    e.st   = st;
    e.ctrl = exp_ctrl(st, mem_ready, ill, err);
    sb.push_back(e);
    @(negedge clk);
    e = sb.pop_front();
    checks++;
    assert (obs_st === e.st) else begin
      errors++;
      $error("FAIL %s state: observed %0d expected %0d", tag, obs_st, e.st);
    end
    checks++;
    assert (obs_ctrl === e.ctrl) else begin
      errors++;
      $error("FAIL %s ctrl: observed %b expected %b", tag, obs_ctrl, e.ctrl);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; op_code = 6'b000000; Zero = 1'b0; mem_ready = 1'b0;
    @(posedge clk);
    #1;
    cycle(4'd0, 1'b0, 1'b0, "reset");
    rst = 1'b0;

    // lw, mem always ready: 0,1,2,3,4,0
    mem_ready = 1'b1; op_code = 6'b100011;
    cycle(4'd0, 1'b0, 1'b0, "lw_fetch");
    cycle(4'd1, 1'b0, 1'b0, "lw_decode");
    cycle(4'd2, 1'b0, 1'b0, "lw_memadr");
    cycle(4'd3, 1'b0, 1'b0, "lw_memrd");
    cycle(4'd4, 1'b0, 1'b0, "lw_memwb");

    op_code = 6'b000000;
    cycle(4'd0, 1'b0, 1'b0, "r_fetch");
    cycle(4'd1, 1'b0, 1'b0, "r_decode");
    cycle(4'd6, 1'b0, 1'b0, "r_exec");
    cycle(4'd7, 1'b0, 1'b0, "r_aluwb");

    op_code = 6'b000100; Zero = 1'b1;
    cycle(4'd0, 1'b0, 1'b0, "beq_fetch");
    cycle(4'd1, 1'b0, 1'b0, "beq_decode");
    cycle(4'd8, 1'b0, 1'b0, "beq_branch");
    Zero = 1'b0;

    op_code = 6'b000010;
    cycle(4'd0, 1'b0, 1'b0, "j_fetch");
    cycle(4'd1, 1'b0, 1'b0, "j_decode");
    cycle(4'd11, 1'b0, 1'b0, "j_jump");

    op_code = 6'b001000;
    cycle(4'd0, 1'b0, 1'b0, "addi_fetch");
    cycle(4'd1, 1'b0, 1'b0, "addi_decode");
    cycle(4'd9, 1'b0, 1'b0, "addi_ex");
    cycle(4'd10, 1'b0, 1'b0, "addi_wb");

    op_code = 6'b111111;
    cycle(4'd0, 1'b0, 1'b0, "ill_fetch");
    cycle(4'd1, 1'b1, 1'b0, "ill_decode");

    // sw with three not-ready cycles in MEMWR
    op_code = 6'b101011;
    cycle(4'd0, 1'b0, 1'b0, "sw_fetch");
    cycle(4'd1, 1'b0, 1'b0, "sw_decode");
    cycle(4'd2, 1'b0, 1'b0, "sw_memadr");
    mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) cycle(4'd5, 1'b0, 1'b0, "sw_wait");
    mem_ready = 1'b1;
    cycle(4'd5, 1'b0, 1'b0, "sw_done");

    // lw answered exactly in the last allowed wait cycle: no error
    op_code = 6'b100011;
    cycle(4'd0, 1'b0, 1'b0, "lwb_fetch");
    cycle(4'd1, 1'b0, 1'b0, "lwb_decode");
    cycle(4'd2, 1'b0, 1'b0, "lwb_memadr");
    mem_ready = 1'b0;
    for (int i = 0; i < 14; i++) cycle(4'd3, 1'b0, 1'b0, "lwb_wait");
    mem_ready = 1'b1;
    cycle(4'd3, 1'b0, 1'b0, "lwb_edge");
    cycle(4'd4, 1'b0, 1'b0, "lwb_memwb");

    // sw never answered: timeout drops MemWrite and returns to FETCH
    op_code = 6'b101011;
    cycle(4'd0, 1'b0, 1'b0, "swt_fetch");
    cycle(4'd1, 1'b0, 1'b0, "swt_decode");
    cycle(4'd2, 1'b0, 1'b0, "swt_memadr");
    mem_ready = 1'b0;
    for (int i = 0; i < 14; i++) cycle(4'd5, 1'b0, 1'b0, "swt_wait");
    cycle(4'd5, 1'b0, 1'b1, "swt_timeout");
    cycle(4'd0, 1'b0, 1'b0, "swt_refetch");

    // reset in the middle of MEMRD
    mem_ready = 1'b1; op_code = 6'b100011;
    cycle(4'd0, 1'b0, 1'b0, "rlw_fetch");
    cycle(4'd1, 1'b0, 1'b0, "rlw_decode");
    cycle(4'd2, 1'b0, 1'b0, "rlw_memadr");
    mem_ready = 1'b0; rst = 1'b1;
    cycle(4'd3, 1'b0, 1'b0, "rlw_memrd");
    rst = 1'b0;
    cycle(4'd0, 1'b0, 1'b0, "rlw_after_rst");

    // MAX_WAIT=4 instance stalled in FETCH
    use4 = 1'b1; rst = 1'b1; op_code = 6'b000000;
    cycle(4'd0, 1'b0, 1'b0, "w4_reset");
    rst = 1'b0;
    for (int i = 0; i < 3; i++) cycle(4'd0, 1'b0, 1'b0, "w4_wait");
    cycle(4'd0, 1'b0, 1'b1, "w4_timeout");
    cycle(4'd0, 1'b0, 1'b0, "w4_restart");
    mem_ready = 1'b1;
    cycle(4'd0, 1'b0, 1'b0, "w4_fetch_ok");
    cycle(4'd1, 1'b0, 1'b0, "w4_decode");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
